// File: rtl/pipe_flush_ctrl_if.sv
// pipe_flush_ctrl_if: request/redirect bundle between the pipeline and pipe_flush_ctrl
//   master: pipeline side, drives PCSrc/B_OP/B_cond/exc_req/stall/targets, observes redirect outputs
//   slave : controller side, samples requests, drives redirect_valid/redirect_pc/kill/pending/flush_count
interface pipe_flush_ctrl_if #(
   parameter int ADDR_W     = 16,
   parameter int NUM_STAGES = 3,
   parameter int CNT_W      = 16
);
   logic [1:0]            PCSrc;
   logic                  B_OP;
   logic                  B_cond;
   logic                  exc_req;
   logic                  stall;
   logic [ADDR_W-1:0]     jmp_target;
   logic [ADDR_W-1:0]     br_target;
   logic                  redirect_valid;
   logic [ADDR_W-1:0]     redirect_pc;
   logic [NUM_STAGES-1:0] kill;
   logic                  pending;
   logic [CNT_W-1:0]      flush_count;
   modport master (
      output PCSrc, B_OP, B_cond, exc_req, stall, jmp_target, br_target,
      input  redirect_valid, redirect_pc, kill, pending, flush_count
   );
   modport slave (
      input  PCSrc, B_OP, B_cond, exc_req, stall, jmp_target, br_target,
      output redirect_valid, redirect_pc, kill, pending, flush_count
   );
endinterface

// File: rtl/pipe_flush_ctrl.sv
// pipe_flush_ctrl: prioritised redirect/flush controller with stall hold and shadow window
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   fc      : slave side of pipe_flush_ctrl_if (requests in, registered redirect/kill/pending/count out)
module pipe_flush_ctrl #(
   parameter int                NUM_STAGES = 3,
   parameter int                ADDR_W     = 16,
   parameter int                JMP_DEPTH  = 1,
   parameter int                BR_DEPTH   = 2,
   parameter int                SHADOW     = 1,
   parameter logic [ADDR_W-1:0] EXC_VECTOR = 'h00F0,
   parameter int                CNT_W      = 16
) (
   input logic               clk,
   input logic               reset_n,
   pipe_flush_ctrl_if.slave  fc
);
   localparam int JD = (JMP_DEPTH > NUM_STAGES) ? NUM_STAGES : JMP_DEPTH;
   localparam int BD = (BR_DEPTH > NUM_STAGES) ? NUM_STAGES : BR_DEPTH;
   localparam logic [NUM_STAGES-1:0] ALL_MASK = '1;
   localparam logic [NUM_STAGES-1:0] JMP_MASK = ALL_MASK >> (NUM_STAGES - JD);
   localparam logic [NUM_STAGES-1:0] BR_MASK  = ALL_MASK >> (NUM_STAGES - BD);
   localparam int SW = (SHADOW > 1) ? $clog2(SHADOW + 1) : 1;
   localparam logic [SW-1:0] SHADOW_LD = SW'(SHADOW);
   // class codes double as priority: a larger code wins
   localparam logic [1:0] C_NONE = 2'd0, C_JMP = 2'd1, C_BR = 2'd2, C_EXC = 2'd3;
   typedef enum logic [1:0] {IDLE, PEND, SHAD} state_t;
   state_t                state_q;
   logic [SW-1:0]         shd_q;
   logic [1:0]            cap_cls_q;
   logic [ADDR_W-1:0]     cap_pc_q;
   logic [NUM_STAGES-1:0] cap_mask_q;
   logic                  rv_q;
   logic [ADDR_W-1:0]     pc_q;
   logic [NUM_STAGES-1:0] kill_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [1:0]            req_cls_d, sel_cls_d;
   logic [ADDR_W-1:0]     req_pc_d, sel_pc_d;
   logic [NUM_STAGES-1:0] req_mask_d, sel_mask_d;
   logic                  take_d, act_d;
   always_comb begin
      req_cls_d  = fc.exc_req ? C_EXC :
                   (fc.PCSrc == 2'd2 || (fc.B_OP && fc.B_cond)) ? C_BR :
                   (fc.PCSrc == 2'd1) ? C_JMP : C_NONE;
      req_pc_d   = (req_cls_d == C_EXC) ? EXC_VECTOR :
                   (req_cls_d == C_BR) ? fc.br_target : fc.jmp_target;
      req_mask_d = (req_cls_d == C_EXC) ? ALL_MASK :
                   (req_cls_d == C_BR) ? BR_MASK :
                   (req_cls_d == C_JMP) ? JMP_MASK : '0;
      // capture is empty outside PEND, so the selection reduces to the incoming request there
      take_d     = req_cls_d >= cap_cls_q;
      sel_cls_d  = take_d ? req_cls_d : cap_cls_q;
      sel_pc_d   = take_d ? req_pc_d : cap_pc_q;
      sel_mask_d = take_d ? req_mask_d : cap_mask_q;
      // inside the shadow window only an exception is honoured
      act_d      = (state_q == SHAD) ? (req_cls_d == C_EXC) : (sel_cls_d != C_NONE);
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         shd_q      <= '0;
         cap_cls_q  <= C_NONE;
         cap_pc_q   <= '0;
         cap_mask_q <= '0;
         rv_q       <= 1'b0;
         pc_q       <= '0;
         kill_q     <= '0;
         cnt_q      <= '0;
      end else begin
         rv_q   <= 1'b0;
         pc_q   <= '0;
         kill_q <= '0;
         if (act_d && fc.stall) begin
            state_q    <= PEND;
            shd_q      <= '0;
            cap_cls_q  <= sel_cls_d;
            cap_pc_q   <= sel_pc_d;
            cap_mask_q <= sel_mask_d;
         end else if (act_d) begin
            rv_q       <= 1'b1;
            pc_q       <= sel_pc_d;
            kill_q     <= sel_mask_d;
            cnt_q      <= (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
            cap_cls_q  <= C_NONE;
            cap_pc_q   <= '0;
            cap_mask_q <= '0;
            state_q    <= (SHADOW > 0) ? SHAD : IDLE;
            shd_q      <= SHADOW_LD;
         end else if (state_q == SHAD) begin
            state_q <= (shd_q <= SW'(1)) ? IDLE : SHAD;
            shd_q   <= (shd_q == '0) ? '0 : shd_q - SW'(1);
         end
      end
   end
   assign fc.redirect_valid = rv_q;
   assign fc.redirect_pc    = pc_q;
   assign fc.kill           = kill_q;
   assign fc.pending        = (state_q == PEND);
   assign fc.flush_count    = cnt_q;
endmodule

// File: tb/tb_pipe_flush_ctrl.sv
// tb_pipe_flush_ctrl: directed self-checking bench for pipe_flush_ctrl (2-bit counter build)
module tb_pipe_flush_ctrl;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   pipe_flush_ctrl_if #(.ADDR_W(16), .NUM_STAGES(3), .CNT_W(2)) fc ();
   pipe_flush_ctrl #(.CNT_W(2)) dut (.clk(clk), .reset_n(reset_n), .fc(fc));
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic out_chk(input string tag, input logic rv, input logic [15:0] pc, input logic [2:0] k);
      chk({tag, "_valid"}, 32'(fc.redirect_valid), 32'(rv));
      chk({tag, "_pc"}, 32'(fc.redirect_pc), 32'(pc));
      chk({tag, "_kill"}, 32'(fc.kill), 32'(k));
   endtask
   task automatic clr();
      fc.PCSrc = 2'd0; fc.B_OP = 1'b0; fc.B_cond = 1'b0; fc.exc_req = 1'b0; fc.stall = 1'b0;
   endtask
   initial begin
      clr();
      fc.jmp_target = 16'h0012;
      fc.br_target = 16'h0040;
      // requests driven during reset must leave no trace
      fc.exc_req = 1'b1; fc.PCSrc = 2'd1; fc.B_OP = 1'b1; fc.B_cond = 1'b1;
      tick(); tick();
      out_chk("rst", 1'b0, 16'h0, 3'b000);
      chk("rst_pending", 32'(fc.pending), 32'd0);
      chk("rst_count", 32'(fc.flush_count), 32'd0);
      clr();
      reset_n = 1'b1;
      tick();
      out_chk("rel", 1'b0, 16'h0, 3'b000);
      chk("rel_count", 32'(fc.flush_count), 32'd0);
      // reserved PCSrc encoding is ignored
      fc.PCSrc = 2'd3;
      tick();
      out_chk("pcsrc3", 1'b0, 16'h0, 3'b000);
      chk("pcsrc3_pending", 32'(fc.pending), 32'd0);
      // taken branch, then a jump in the shadow is ignored, then accepted after it
      clr(); fc.B_OP = 1'b1; fc.B_cond = 1'b1; fc.br_target = 16'h0040;
      tick();
      out_chk("br", 1'b1, 16'h0040, 3'b011);
      chk("br_count", 32'(fc.flush_count), 32'd1);
      clr(); fc.PCSrc = 2'd1; fc.jmp_target = 16'h0012;
      tick();
      out_chk("shadow_jmp", 1'b0, 16'h0, 3'b000);
      chk("shadow_count", 32'(fc.flush_count), 32'd1);
      tick();
      out_chk("post_shadow_jmp", 1'b1, 16'h0012, 3'b001);
      chk("post_shadow_count", 32'(fc.flush_count), 32'd2);
      clr();
      tick(); tick();
      // branch condition false is not a request
      fc.B_OP = 1'b1; fc.B_cond = 1'b0;
      tick();
      out_chk("br_nt", 1'b0, 16'h0, 3'b000);
      clr();
      // stalled jump held for three cycles
      fc.stall = 1'b1; fc.PCSrc = 2'd1; fc.jmp_target = 16'h0012;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_pending", 32'(fc.pending), 32'd1);
         chk("stall_valid", 32'(fc.redirect_valid), 32'd0);
      end
      clr();
      tick();
      out_chk("release", 1'b1, 16'h0012, 3'b001);
      chk("release_pending", 32'(fc.pending), 32'd0);
      chk("release_count", 32'(fc.flush_count), 32'd3);
      tick(); tick();
      // JMP captured, BR overwrites, then a lower JMP is dropped
      fc.stall = 1'b1; fc.PCSrc = 2'd1; fc.jmp_target = 16'h0012;
      tick();
      fc.PCSrc = 2'd2; fc.br_target = 16'h0080;
      tick();
      chk("ovw_pending", 32'(fc.pending), 32'd1);
      chk("ovw_valid", 32'(fc.redirect_valid), 32'd0);
      fc.PCSrc = 2'd1; fc.jmp_target = 16'h0034;
      tick();
      fc.PCSrc = 2'd0; fc.stall = 1'b0;
      tick();
      out_chk("ovw", 1'b1, 16'h0080, 3'b011);
      chk("ovw_count_sat", 32'(fc.flush_count), 32'd3);
      tick();
      out_chk("ovw_single", 1'b0, 16'h0, 3'b000);
      tick();
      // reset mid-PEND discards the capture
      fc.stall = 1'b1; fc.PCSrc = 2'd1;
      tick();
      chk("midpend_pending", 32'(fc.pending), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("async_pending", 32'(fc.pending), 32'd0);
      chk("async_count", 32'(fc.flush_count), 32'd0);
      clr();
      tick();
      reset_n = 1'b1;
      tick();
      out_chk("midpend_after", 1'b0, 16'h0, 3'b000);
      tick();
      chk("midpend_after2", 32'(fc.redirect_valid), 32'd0);
      // EXC+BR+JMP together, then a second EXC inside the shadow
      fc.exc_req = 1'b1; fc.PCSrc = 2'd1; fc.B_OP = 1'b1; fc.B_cond = 1'b1;
      fc.br_target = 16'h0040; fc.jmp_target = 16'h0012;
      tick();
      out_chk("exc", 1'b1, 16'h00F0, 3'b111);
      chk("exc_count", 32'(fc.flush_count), 32'd1);
      clr(); fc.exc_req = 1'b1;
      tick();
      out_chk("exc_shadow", 1'b1, 16'h00F0, 3'b111);
      chk("exc_count2", 32'(fc.flush_count), 32'd2);
      clr(); fc.PCSrc = 2'd1;
      tick();
      out_chk("exc_reload_shadow", 1'b0, 16'h0, 3'b000);
      clr();
      tick();
      // saturation of the 2-bit counter
      reset_n = 1'b0;
      #1;
      reset_n = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) begin
         fc.B_OP = 1'b1; fc.B_cond = 1'b1;
         tick();
         chk("sat_valid", 32'(fc.redirect_valid), 32'd1);
         chk("sat_count", 32'(fc.flush_count), (i < 3) ? 32'(i + 1) : 32'd3);
         clr();
         tick(); tick();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pipe_flush_ctrl.md
# pipe_flush_ctrl

Parametrised pipeline redirect and flush controller for the 16-bit pipelined core. It collects redirect requests from the jump (ID), branch/jump-register (EX) and exception sources, prioritises them, and holds a request while the pipeline is stalled. It issues a single registered redirect with a per-stage kill mask, and suppresses spurious requests from squashed instructions during a shadow window. It replaces the single-bit flush signal and feeds the PC-select mux and the pipeline-register bubble inputs.

## Interface
- NUM_STAGES, 3: pipeline registers that can be killed (bit 0 = IF/ID, bit 1 = ID/EX, ...).
- ADDR_W, 16: PC width.
- JMP_DEPTH, 1: stages killed by a jump.
- BR_DEPTH, 2: stages killed by a taken branch or jump-register.
- SHADOW, 1: cycles after an issue during which jump/branch requests are ignored.
- EXC_VECTOR, 16'h00F0: exception target PC.
- CNT_W, 16: statistics counter width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- PCSrc  in  2  0 = sequential, 1 = jump (ID), 2 = jump-register (EX), 3 = reserved (treated as 0).
- B_OP  in  1  EX holds a branch.
- B_cond  in  1  branch condition true.
- exc_req  in  1  exception request.
- stall  in  1  pipeline stall from the hazard unit.
- jmp_target  in  ADDR_W  jump target.
- br_target  in  ADDR_W  branch / jump-register target.
- redirect_valid  out  1  registered, one-cycle PC redirect.
- redirect_pc  out  ADDR_W  target qualified by redirect_valid.
- kill  out  NUM_STAGES  registered per-stage bubble mask.
- pending  out  1  a request is held awaiting stall release.
- flush_count  out  CNT_W  issued redirects, saturating.

## Operation
Request classes, highest priority first:
- EXC (exc_req): target EXC_VECTOR, kill all NUM_STAGES bits.
- BR (PCSrc==2, or B_OP && B_cond): target br_target, kill low BR_DEPTH bits.
- JMP (PCSrc==1): target jmp_target, kill low JMP_DEPTH bits.

Only the highest-priority class present in a cycle is taken. Depth parameters are clipped to NUM_STAGES.

States:
- IDLE
  - Request and stall=0: issue, go to SHADOW (or IDLE if SHADOW==0).
  - Request and stall=1: capture class/target/mask, go to PEND.
- PEND
  - pending=1. An incoming request of equal or higher priority overwrites the capture; a lower one is dropped.
  - First edge with stall=0: issue the capture (or the overwriting request sampled that edge), go to SHADOW.
- SHADOW
  - Counter loaded with SHADOW, decrements each cycle.
  - JMP/BR requests ignored. EXC is always accepted and behaves as in IDLE.
  - Counter reaching 0: go to IDLE.

Issue means: for exactly one cycle, redirect_valid=1, redirect_pc=target, kill=mask; flush_count += 1, saturating at all-ones.

Outputs are 0 in every cycle that is not an issue cycle. PCSrc==3 is ignored.

## Timing
- Reset (async, reset_n low): state IDLE, all outputs 0, shadow counter 0, capture cleared.
- Latency: request sampled at edge N, redirect/kill visible during cycle N..N+1. No combinational path from inputs to outputs.
- Stall release: issue at the first edge sampling stall=0 while in PEND.
- EXC during SHADOW: issued at the next edge and reloads the shadow counter.
- Reset mid-PEND or mid-SHADOW: capture discarded, no issue after reset release.
- Simultaneous EXC + BR + JMP: only EXC issues, and one redirect only.

## Test plan
- Reset: drive requests with reset_n low, then release → all outputs 0, flush_count=0, no issue on the release edge.
- Taken branch: B_OP=1, B_cond=1, br_target=16'h0040, stall=0 → next cycle redirect_valid=1, redirect_pc=16'h0040, kill=3'b011. A JMP the following cycle is ignored (SHADOW=1). flush_count=1.
- Stalled jump: PCSrc=1, jmp_target=16'h0012 under stall=1 for 3 cycles → pending=1 throughout, no redirect. Stall drops → redirect 16'h0012, kill=3'b001, pending=0.
- Overwrite in PEND: JMP captured under stall, BR (br_target=16'h0080) arrives next cycle → after stall release a single redirect to 16'h0080, kill=3'b011.
- Priority and shadow: EXC+BR+JMP in the same cycle → redirect 16'h00F0, kill=3'b111. A second EXC during SHADOW issues again; flush_count=2.
- Saturation: CNT_W=2, 5 separated branches → flush_count sticks at 3.
